// File: rtl/mem_pkg.sv
// Shared definitions for the wait-state memory controller and its word array.
package mem_pkg;

    // Data path is fixed at one 32-bit word with four byte lanes
    localparam int MEM_DATA_W = 32;
    localparam int MEM_LANES  = MEM_DATA_W / 8;

    // Default byte address of word 0
    localparam logic [31:0] MEM_BASE_ADDR = 32'h0;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/mem_word_array.sv
// Single-port DEPTH x 32 word array with byte-lane write enables and registered read.
module mem_word_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [MEM_LANES-1:0]  byte_en,
    input  logic [IDX_W-1:0]      idx,
    input  logic [MEM_DATA_W-1:0] wdata,
    output logic [MEM_DATA_W-1:0] rdata
);

    logic [MEM_DATA_W-1:0] mem_q [DEPTH];
    logic [MEM_DATA_W-1:0] rdata_q;

    // One port: a lane-masked write or a registered read per edge, never cleared
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < MEM_LANES; i++) begin
                if (byte_en[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_wait_ctrl.sv
// Wait-state memory controller: accepts one arbiter request at a time, checks the
// address at accept, services it after WAIT_CYCLES and pulses memReady/memErr.
module mem_wait_ctrl
    import mem_pkg::*;
#(
    parameter int              ADDR_W      = 32,
    parameter int              DATA_W      = MEM_DATA_W,
    parameter int              DEPTH       = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(MEM_BASE_ADDR),
    parameter int              WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 memReq,
    input  logic [ADDR_W-1:0]    memAddr,
    input  logic                 memWr,
    input  logic [MEM_LANES-1:0] memByteEn,
    input  logic [DATA_W-1:0]    memDataWr,
    output logic [DATA_W-1:0]    memDataRd,
    output logic                 memReady,
    output logic                 memBusy,
    output logic                 memIdle,
    output logic                 memErr
);

    localparam int              IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LIMIT    = (ADDR_W+1)'(DEPTH * 4);
    localparam logic [3:0]      CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 err_q, err_d;
    logic                 rd_zero_q, rd_zero_d;

    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 wr_q, wr_d;
    logic [MEM_LANES-1:0] be_q, be_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 fault_q, fault_d;

    logic [ADDR_W:0]      diff_now;
    logic                 fault_now;
    logic [IDX_W-1:0]     idx_now;
    logic                 in_idle;
    logic                 accept;
    logic                 enter_resp;

    logic [IDX_W-1:0]     op_idx;
    logic                 op_wr;
    logic [MEM_LANES-1:0] op_be;
    logic [DATA_W-1:0]    op_wdata;
    logic                 op_fault;

    logic                 arr_we;
    logic                 arr_re;
    logic [DATA_W-1:0]    arr_rdata;

    // Address check on the live request; the extra top bit flags addr < BASE_ADDR
    always_comb begin
        diff_now  = {1'b0, memAddr} - {1'b0, BASE_ADDR};
        fault_now = diff_now[ADDR_W]
                  | ({1'b0, diff_now[ADDR_W-1:0]} >= LIMIT)
                  | (memAddr[1:0] != 2'b00);
        idx_now   = diff_now[IDX_W+1:2];
        in_idle   = (state_q == ST_IDLE);
        accept    = in_idle & memReq;
    end

    // Capture the request at accept; when leaving IDLE straight to RESP use it live
    always_comb begin
        idx_d    = accept ? idx_now   : idx_q;
        wr_d     = accept ? memWr     : wr_q;
        be_d     = accept ? memByteEn : be_q;
        wdata_d  = accept ? memDataWr : wdata_q;
        fault_d  = accept ? fault_now : fault_q;
        op_idx   = in_idle ? idx_now   : idx_q;
        op_wr    = in_idle ? memWr     : wr_q;
        op_be    = in_idle ? memByteEn : be_q;
        op_wdata = in_idle ? memDataWr : wdata_q;
        op_fault = in_idle ? fault_now : fault_q;
    end

    // IDLE -> WAIT -> RESP -> IDLE; memReady/memErr register on the edge leaving RESP
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        rd_zero_d  = rd_zero_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (memReq) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                err_d   = fault_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Read data is replaced by a good read or forced to zero by a fault
        if (enter_resp && (op_fault || !op_wr)) begin
            rd_zero_d = op_fault;
        end
        // Gate array access with reset so an aborted request never touches the array
        arr_we = enter_resp & ~op_fault &  op_wr & ~reset;
        arr_re = enter_resp & ~op_fault & ~op_wr & ~reset;
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rd_zero_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            rd_zero_q <= rd_zero_d;
        end
    end

    // Latched request fields; only meaningful while a request is in flight
    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wr_q    <= wr_d;
        be_q    <= be_d;
        wdata_q <= wdata_d;
        fault_q <= fault_d;
    end

    mem_word_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .we      (arr_we),
        .re      (arr_re),
        .byte_en (op_be),
        .idx     (op_idx),
        .wdata   (op_wdata),
        .rdata   (arr_rdata)
    );

    assign memDataRd = rd_zero_q ? '0 : arr_rdata;
    assign memReady  = ready_q;
    assign memErr    = err_q;
    assign memIdle   = (state_q == ST_IDLE);
    assign memBusy   = ~memIdle;

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Bench for mem_wait_ctrl: a WAIT_CYCLES=2 instance driven from a vector table and
// corner-case sequences, plus a WAIT_CYCLES=0 instance for latency and throughput.
module tb_mem_wait_ctrl;

    localparam int DEPTH = 1024;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst;
    logic [1:0]       req;
    logic [1:0][31:0] addr;
    logic [1:0]       wr;
    logic [1:0][3:0]  be;
    logic [1:0][31:0] wd;
    logic [1:0][31:0] rd;
    logic [1:0]       rdy;
    logic [1:0]       busy;
    logic [1:0]       idle;
    logic [1:0]       err;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    int   rq0[$];
    int   rq1[$];
    vec_t vecs[17];

    mem_wait_ctrl #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .reset(rst[0]), .memReq(req[0]), .memAddr(addr[0]), .memWr(wr[0]),
        .memByteEn(be[0]), .memDataWr(wd[0]), .memDataRd(rd[0]), .memReady(rdy[0]),
        .memBusy(busy[0]), .memIdle(idle[0]), .memErr(err[0])
    );

    mem_wait_ctrl #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset(rst[1]), .memReq(req[1]), .memAddr(addr[1]), .memWr(wr[1]),
        .memByteEn(be[1]), .memDataWr(wd[1]), .memDataRd(rd[1]), .memReady(rdy[1]),
        .memBusy(busy[1]), .memIdle(idle[1]), .memErr(err[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wc(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle output monitor and scoreboard pop on memReady
    task automatic mon(input int d);
        exp_t e;
        int   n;
        chk($sformatf("idle_xor_busy[%0d]", d), {31'b0, idle[d] ^ busy[d]}, 32'd1);
        chk($sformatf("err_qualified[%0d]", d), {31'b0, err[d] & ~rdy[d]}, 32'd0);
        if (rdy[d] === 1'b1) begin
            if (d == 0) rq0.push_back(cyc); else rq1.push_back(cyc);
            n = (d == 0) ? sb0.size() : sb1.size();
            if (n == 0) begin
                chk($sformatf("spurious_ready[%0d]", d), 32'd1, 32'd0);
            end else begin
                e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                chk($sformatf("ready_cycle[%0d]", d), 32'(cyc), 32'(e.cyc));
                chk($sformatf("err[%0d]", d), {31'b0, err[d]}, {31'b0, e.err});
                chk($sformatf("rdata[%0d]", d), rd[d], e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Issue one request when idle; returns at the negedge after the accept edge
    task automatic do_req(input int d, input logic [31:0] a, input logic w, input logic [3:0] b,
                          input logic [31:0] data, input logic exp_err, input logic [31:0] exp_data,
                          input bit push);
        exp_t e;
        int   g = 0;
        while (idle[d] !== 1'b1 && g < 64) begin
            @(negedge clk);
            g++;
        end
        if (g >= 64) chk($sformatf("idle_timeout[%0d]", d), 32'd0, 32'd1);
        req[d] = 1'b1; addr[d] = a; wr[d] = w; be[d] = b; wd[d] = data;
        if (push) begin
            e.cyc  = cyc + 2 + wc(d);
            e.err  = exp_err;
            e.data = exp_data;
            if (d == 0) sb0.push_back(e); else sb1.push_back(e);
        end
        @(negedge clk);
        req[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int g = 0;
        while (((d == 0) ? sb0.size() : sb1.size()) != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            chk($sformatf("drain_timeout[%0d]", d), 32'd0, 32'd1);
            if (d == 0) sb0.delete(); else sb1.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 2'b11; req = '0; addr = '0; wr = '0; be = '0; wd = '0;

        vecs[0]  = '{32'h0000_0010, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{32'h0000_0010, 1'b0, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{32'h0000_0020, 1'b1, 4'hF, 32'h11223344, 1'b0, 32'hDEADBEEF};
        vecs[3]  = '{32'h0000_0020, 1'b1, 4'h5, 32'hAABBCCDD, 1'b0, 32'hDEADBEEF};
        vecs[4]  = '{32'h0000_0020, 1'b0, 4'hF, 32'h0,        1'b0, 32'h11BB33DD};
        vecs[5]  = '{32'h0000_0003, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0000_0000};
        vecs[6]  = '{32'h0000_0000, 1'b1, 4'hF, 32'h01020304, 1'b0, 32'h0000_0000};
        vecs[7]  = '{32'h0000_0000, 1'b0, 4'hF, 32'h0,        1'b0, 32'h01020304};
        vecs[8]  = '{32'h0000_1000, 1'b1, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0000_0000};
        vecs[9]  = '{32'h0000_0000, 1'b0, 4'hF, 32'h0,        1'b0, 32'h01020304};
        vecs[10] = '{32'h0000_0030, 1'b1, 4'hF, 32'h12345678, 1'b0, 32'h01020304};
        vecs[11] = '{32'h0000_0FFC, 1'b1, 4'hF, 32'h5A5A5A5A, 1'b0, 32'h01020304};
        vecs[12] = '{32'h0000_0FFC, 1'b0, 4'hF, 32'h0,        1'b0, 32'h5A5A5A5A};
        vecs[13] = '{32'h0000_0FFC, 1'b1, 4'h0, 32'h00000000, 1'b0, 32'h5A5A5A5A};
        vecs[14] = '{32'h0000_0FFC, 1'b0, 4'hF, 32'h0,        1'b0, 32'h5A5A5A5A};
        vecs[15] = '{32'h0000_1000, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0000_0000};
        vecs[16] = '{32'h0000_0030, 1'b0, 4'hF, 32'h0,        1'b0, 32'h12345678};

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_ready[%0d]", d), {31'b0, rdy[d]},  32'd0);
            chk($sformatf("reset_busy[%0d]", d),  {31'b0, busy[d]}, 32'd0);
            chk($sformatf("reset_idle[%0d]", d),  {31'b0, idle[d]}, 32'd1);
            chk($sformatf("reset_err[%0d]", d),   {31'b0, err[d]},  32'd0);
            chk($sformatf("reset_rdata[%0d]", d), rd[d],            32'd0);
        end
        rst = 2'b00;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            do_req(0, vecs[i].addr, vecs[i].wr, vecs[i].be, vecs[i].wdata,
                   vecs[i].exp_err, vecs[i].exp_data, 1'b1);
        end
        drain(0);

        // A second request raised during WAIT is ignored; busy holds through RESP
        do_req(0, 32'h10, 1'b0, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
        req[0] = 1'b1; addr[0] = 32'h20; wr[0] = 1'b0;
        chk("ignore_busy_w1", {31'b0, busy[0]}, 32'd1);
        chk("ignore_idle_w1", {31'b0, idle[0]}, 32'd0);
        @(negedge clk);
        req[0] = 1'b0;
        chk("ignore_busy_w2", {31'b0, busy[0]}, 32'd1);
        chk("ignore_idle_w2", {31'b0, idle[0]}, 32'd0);
        @(negedge clk);
        chk("ignore_busy_resp", {31'b0, busy[0]}, 32'd1);
        chk("ignore_ready_resp", {31'b0, rdy[0]}, 32'd0);
        @(negedge clk);
        chk("ignore_idle_after", {31'b0, idle[0]}, 32'd1);
        drain(0);

        // Reset during WAIT of a write aborts it without touching the array
        do_req(0, 32'h30, 1'b1, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("abort_idle",  {31'b0, idle[0]}, 32'd1);
        chk("abort_busy",  {31'b0, busy[0]}, 32'd0);
        chk("abort_err",   {31'b0, err[0]},  32'd0);
        chk("abort_rdata", rd[0],            32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("abort_no_ready", {31'b0, rdy[0]}, 32'd0);
            @(negedge clk);
        end
        do_req(0, 32'h30, 1'b0, 4'hF, 32'h0, 1'b0, 32'h12345678, 1'b1);
        drain(0);

        // Zero-wait build: one-cycle latency and a request every 2 cycles
        do_req(1, 32'h10, 1'b1, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1);
        do_req(1, 32'h10, 1'b0, 4'hF, 32'h0, 1'b0, 32'hCAFEF00D, 1'b1);
        do_req(1, 32'h3,  1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1'b1);
        drain(1);
        rq1.delete();
        for (int k = 0; k < 3; k++) begin
            do_req(1, 32'h10, 1'b0, 4'hF, 32'h0, 1'b0, 32'hCAFEF00D, 1'b1);
        end
        drain(1);
        chk("w0_b2b_count", 32'(rq1.size()), 32'd3);
        if (rq1.size() == 3) begin
            chk("w0_b2b_gap1", 32'(rq1[1] - rq1[0]), 32'd2);
            chk("w0_b2b_gap2", 32'(rq1[2] - rq1[1]), 32'd2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
